// File: rtl/bird_physics.sv
// Per-frame vertical motion engine for the bird: integrates gravity and flap
// impulses on each frame tick and runs the IDLE/FLYING/DEAD game state.
module bird_physics #(
  parameter int Y_START  = 240,
  parameter int GRAVITY  = 1,
  parameter int FLAP_VEL = -6,
  parameter int MAX_FALL = 7,
  parameter int Y_TOP    = 6,
  parameter int Y_BOTTOM = 474
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        flap,
  input  logic        hit_pipe,
  output logic [31:0] bird_y,
  output logic [7:0]  bird_vel,
  output logic        playing,
  output logic        game_over
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FLYING = 2'd1;
  localparam logic [1:0] ST_DEAD   = 2'd2;

  localparam logic        [9:0]  Y_START10  = 10'(Y_START);
  localparam logic        [9:0]  Y_TOP10    = 10'(Y_TOP);
  localparam logic        [9:0]  Y_BOTTOM10 = 10'(Y_BOTTOM);
  localparam logic signed [11:0] Y_TOP12    = 12'(Y_TOP);
  localparam logic signed [11:0] Y_BOTTOM12 = 12'(Y_BOTTOM);
  localparam logic signed [11:0] GRAV12     = 12'(GRAVITY);
  localparam logic signed [11:0] MAXF12     = 12'(MAX_FALL);
  localparam logic signed [7:0]  MAXF8      = 8'(MAX_FALL);
  localparam logic signed [7:0]  FLAP8      = 8'(FLAP_VEL);

  logic [1:0]         state_q, state_d;
  logic [9:0]         y_q, y_d;
  logic signed [7:0]  vel_q, vel_d;
  logic               flap_prev_q;
  logic               flap_pending_q, flap_pending_d;

  logic               flap_edge;
  logic               flap_eff;
  logic signed [11:0] vel_grav;
  logic signed [7:0]  vel_sel;
  logic signed [11:0] y_sum;
  logic [9:0]         move_y;
  logic signed [7:0]  move_vel;
  logic               move_dead;

  // An edge in the tick cycle itself counts; pending collapses many edges into one flap.
  always_comb begin
    flap_edge      = flap & ~flap_prev_q;
    flap_eff       = flap_pending_q | flap_edge;
    flap_pending_d = frame_tick ? 1'b0 : (flap_pending_q | flap_edge);
  end

  // Candidate motion for this tick, clamped to the ceiling and the ground.
  always_comb begin
    vel_grav  = {{4{vel_q[7]}}, vel_q} + GRAV12;
    vel_sel   = flap_eff ? FLAP8 : ((vel_grav > MAXF12) ? MAXF8 : vel_grav[7:0]);
    y_sum     = $signed({2'b00, y_q}) + {{4{vel_sel[7]}}, vel_sel};
    move_y    = y_sum[9:0];
    move_vel  = vel_sel;
    move_dead = 1'b0;
    if (y_sum <= Y_TOP12) begin
      move_y   = Y_TOP10;
      move_vel = '0;
    end else if (y_sum >= Y_BOTTOM12) begin
      move_y    = Y_BOTTOM10;
      move_vel  = '0;
      move_dead = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
    case (state_q)
      ST_IDLE: begin
        y_d   = Y_START10;
        vel_d = '0;
        if (frame_tick && flap_eff) begin
          state_d = move_dead ? ST_DEAD : ST_FLYING;
          y_d     = move_y;
          vel_d   = move_vel;
        end
      end
      ST_FLYING: begin
        // A pipe hit freezes the bird and wins over a coincident tick.
        if (hit_pipe) begin
          state_d = ST_DEAD;
        end else if (frame_tick) begin
          state_d = move_dead ? ST_DEAD : ST_FLYING;
          y_d     = move_y;
          vel_d   = move_vel;
        end
      end
      ST_DEAD: begin
        if (frame_tick && flap_eff) begin
          state_d = ST_IDLE;
          y_d     = Y_START10;
          vel_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        y_d     = Y_START10;
        vel_d   = '0;
      end
    endcase
  end

  // flap_prev resets high so a button held through reset does not flap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      y_q            <= Y_START10;
      vel_q          <= '0;
      flap_prev_q    <= 1'b1;
      flap_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      y_q            <= y_d;
      vel_q          <= vel_d;
      flap_prev_q    <= flap;
      flap_pending_q <= flap_pending_d;
    end
  end

  assign bird_y    = {22'd0, y_q};
  assign bird_vel  = vel_q;
  assign playing   = (state_q == ST_FLYING);
  assign game_over = (state_q == ST_DEAD);

endmodule

// File: tb/tb_bird_physics.sv
// Directed self-checking bench for bird_physics with default parameters;
// expected trajectories are hand-computed from the motion rules.
module tb_bird_physics;

  logic        clock = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        flap;
  logic        hit_pipe;
  logic [31:0] bird_y;
  logic [7:0]  bird_vel;
  logic        playing;
  logic        game_over;

  int testsRun    = 0;
  int testsFailed = 0;

  bird_physics dut (
    .clock      (clock),
    .reset      (reset),
    .frame_tick (frame_tick),
    .flap       (flap),
    .hit_pipe   (hit_pipe),
    .bird_y     (bird_y),
    .bird_vel   (bird_vel),
    .playing    (playing),
    .game_over  (game_over)
  );

  always #5 clock = ~clock;

  // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
  task automatic cycle(input logic t, input logic f, input logic h);
    @(negedge clock);
    frame_tick = t;
    flap       = f;
    hit_pipe   = h;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flap = 1'b1; frame_tick = 1'b0; hit_pipe = 1'b0;
    #12;
    testsRun++;
    if (bird_y !== 32'd240 || $signed(bird_vel) !== 0 || playing !== 1'b0 || game_over !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_values: y=%0d vel=%0d play=%b over=%b, expected y=240 vel=0 play=0 over=0", bird_y, $signed(bird_vel), playing, game_over);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      testsRun++;
      if (bird_y !== 32'd240 || $signed(bird_vel) !== 0 || playing !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL held_flap_tick%0d: y=%0d vel=%0d play=%b, expected y=240 vel=0 play=0", i, bird_y, $signed(bird_vel), playing);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      testsRun++;
      if (bird_y !== 32'd240 || $signed(bird_vel) !== 0 || playing !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL idle_tick%0d: y=%0d vel=%0d play=%b, expected y=240 vel=0 play=0", i, bird_y, $signed(bird_vel), playing);
      end
    end
  endtask

  task automatic test_first_flap();
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    testsRun++;
    if (playing !== 1'b0 || bird_y !== 32'd240) begin
      testsFailed++;
      $display("[TB] FAIL pending_no_tick: y=%0d play=%b, expected y=240 play=0", bird_y, playing);
    end
    cycle(1'b1, 1'b0, 1'b0);
    testsRun++;
    if (bird_y !== 32'd234 || $signed(bird_vel) !== -6 || playing !== 1'b1 || game_over !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL first_flap: y=%0d vel=%0d play=%b over=%b, expected y=234 vel=-6 play=1 over=0", bird_y, $signed(bird_vel), playing, game_over);
    end
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    testsRun++;
    if (bird_y !== 32'd229 || $signed(bird_vel) !== -5) begin
      testsFailed++;
      $display("[TB] FAIL first_gravity: y=%0d vel=%0d, expected y=229 vel=-5", bird_y, $signed(bird_vel));
    end
  endtask

  task automatic test_gravity_saturation();
    int expY[14] = '{225, 222, 220, 219, 219, 220, 222, 225, 229, 234, 240, 247, 254, 261};
    int expV[14] = '{-4, -3, -2, -1, 0, 1, 2, 3, 4, 5, 6, 7, 7, 7};
    for (int i = 0; i < 14; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      testsRun++;
      if (bird_y !== 32'(expY[i]) || $signed(bird_vel) !== expV[i] || playing !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL fall_tick%0d: y=%0d vel=%0d play=%b, expected y=%0d vel=%0d play=1", i, bird_y, $signed(bird_vel), playing, expY[i], expV[i]);
      end
    end
  endtask

  task automatic test_ground();
    for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0, 1'b0);
    testsRun++;
    if (bird_y !== 32'd471 || $signed(bird_vel) !== 7 || playing !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL near_ground: y=%0d vel=%0d play=%b, expected y=471 vel=7 play=1", bird_y, $signed(bird_vel), playing);
    end
    cycle(1'b1, 1'b0, 1'b0);
    testsRun++;
    if (bird_y !== 32'd474 || $signed(bird_vel) !== 0 || playing !== 1'b0 || game_over !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL ground_hit: y=%0d vel=%0d play=%b over=%b, expected y=474 vel=0 play=0 over=1", bird_y, $signed(bird_vel), playing, game_over);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      testsRun++;
      if (bird_y !== 32'd474 || game_over !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL dead_hold%0d: y=%0d over=%b, expected y=474 over=1", i, bird_y, game_over);
      end
    end
    cycle(1'b0, 1'b0, 1'b1);
    testsRun++;
    if (bird_y !== 32'd474 || game_over !== 1'b1 || playing !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL dead_ignores_hit: y=%0d over=%b play=%b, expected y=474 over=1 play=0", bird_y, game_over, playing);
    end
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    testsRun++;
    if (bird_y !== 32'd240 || $signed(bird_vel) !== 0 || playing !== 1'b0 || game_over !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL restart: y=%0d vel=%0d play=%b over=%b, expected y=240 vel=0 play=0 over=0", bird_y, $signed(bird_vel), playing, game_over);
    end
  endtask

  task automatic test_idle_ignores_hit();
    cycle(1'b1, 1'b0, 1'b1);
    testsRun++;
    if (bird_y !== 32'd240 || playing !== 1'b0 || game_over !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL idle_hit: y=%0d play=%b over=%b, expected y=240 play=0 over=0", bird_y, playing, game_over);
    end
  endtask

  task automatic test_ceiling();
    cycle(1'b1, 1'b1, 1'b0);
    testsRun++;
    if (bird_y !== 32'd234 || $signed(bird_vel) !== -6 || playing !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL edge_in_tick: y=%0d vel=%0d play=%b, expected y=234 vel=-6 play=1", bird_y, $signed(bird_vel), playing);
    end
    for (int i = 0; i < 37; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0);
    end
    testsRun++;
    if (bird_y !== 32'd12 || $signed(bird_vel) !== -6) begin
      testsFailed++;
      $display("[TB] FAIL climb: y=%0d vel=%0d, expected y=12 vel=-6", bird_y, $signed(bird_vel));
    end
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    testsRun++;
    if (bird_y !== 32'd6 || $signed(bird_vel) !== 0 || playing !== 1'b1 || game_over !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL ceiling_clamp: y=%0d vel=%0d play=%b over=%b, expected y=6 vel=0 play=1 over=0", bird_y, $signed(bird_vel), playing, game_over);
    end
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    testsRun++;
    if (bird_y !== 32'd7 || $signed(bird_vel) !== 1) begin
      testsFailed++;
      $display("[TB] FAIL after_ceiling: y=%0d vel=%0d, expected y=7 vel=1", bird_y, $signed(bird_vel));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0);
    testsRun++;
    if (bird_y !== 32'd41 || $signed(bird_vel) !== 7) begin
      testsFailed++;
      $display("[TB] FAIL back_to_back: y=%0d vel=%0d, expected y=41 vel=7", bird_y, $signed(bird_vel));
    end
  endtask

  task automatic test_double_flap();
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    testsRun++;
    if (bird_y !== 32'd35 || $signed(bird_vel) !== -6) begin
      testsFailed++;
      $display("[TB] FAIL double_flap: y=%0d vel=%0d, expected y=35 vel=-6", bird_y, $signed(bird_vel));
    end
    cycle(1'b1, 1'b0, 1'b0);
    testsRun++;
    if (bird_y !== 32'd30 || $signed(bird_vel) !== -5) begin
      testsFailed++;
      $display("[TB] FAIL pending_cleared: y=%0d vel=%0d, expected y=30 vel=-5", bird_y, $signed(bird_vel));
    end
  endtask

  task automatic test_hit_pipe();
    cycle(1'b1, 1'b0, 1'b1);
    testsRun++;
    if (bird_y !== 32'd30 || $signed(bird_vel) !== -5 || playing !== 1'b0 || game_over !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL hit_with_tick: y=%0d vel=%0d play=%b over=%b, expected y=30 vel=-5 play=0 over=1", bird_y, $signed(bird_vel), playing, game_over);
    end
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    testsRun++;
    if (bird_y !== 32'd30 || $signed(bird_vel) !== -5 || game_over !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL dead_freeze: y=%0d vel=%0d over=%b, expected y=30 vel=-5 over=1", bird_y, $signed(bird_vel), game_over);
    end
    cycle(1'b1, 1'b1, 1'b0);
    testsRun++;
    if (bird_y !== 32'd240 || $signed(bird_vel) !== 0 || playing !== 1'b0 || game_over !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL dead_to_idle: y=%0d vel=%0d play=%b over=%b, expected y=240 vel=0 play=0 over=0", bird_y, $signed(bird_vel), playing, game_over);
    end
    cycle(1'b1, 1'b0, 1'b0);
    testsRun++;
    if (playing !== 1'b0 || bird_y !== 32'd240) begin
      testsFailed++;
      $display("[TB] FAIL idle_after_restart: y=%0d play=%b, expected y=240 play=0", bird_y, playing);
    end
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    testsRun++;
    if (bird_y !== 32'd234 || $signed(bird_vel) !== -6 || game_over !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL hit_no_tick: y=%0d vel=%0d over=%b, expected y=234 vel=-6 over=1", bird_y, $signed(bird_vel), game_over);
    end
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 1'b1, 1'b0);
    testsRun++;
    if (bird_y !== 32'd234 || playing !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL prereset_flight: y=%0d play=%b, expected y=234 play=1", bird_y, playing);
    end
    #2;
    reset = 1'b1;
    flap  = 1'b1;
    #1;
    testsRun++;
    if (bird_y !== 32'd240 || $signed(bird_vel) !== 0 || playing !== 1'b0 || game_over !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL async_reset: y=%0d vel=%0d play=%b over=%b, expected y=240 vel=0 play=0 over=0", bird_y, $signed(bird_vel), playing, game_over);
    end
    @(negedge clock);
    reset = 1'b0;
    cycle(1'b1, 1'b1, 1'b0);
    testsRun++;
    if (playing !== 1'b0 || bird_y !== 32'd240) begin
      testsFailed++;
      $display("[TB] FAIL held_through_reset: y=%0d play=%b, expected y=240 play=0", bird_y, playing);
    end
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    testsRun++;
    if (bird_y !== 32'd234 || $signed(bird_vel) !== -6 || playing !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL post_reset_flap: y=%0d vel=%0d play=%b, expected y=234 vel=-6 play=1", bird_y, $signed(bird_vel), playing);
    end
  endtask

  initial begin
    test_reset();
    test_first_flap();
    test_gravity_saturation();
    test_ground();
    test_idle_ignores_hit();
    test_ceiling();
    test_back_to_back();
    test_double_flap();
    test_hit_pipe();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
